add_issue_arb: RTL and testbench
================================

Name: add_issue_arb

Overview:
- Issue scheduler for the add/sub/logic/branch functional unit.
- Shares the single FU among NUM_RS reservation-station entries using round-robin selection.
- Drives the FU's valid_in/ready handshake and requests CDB write-back for the FU result.
- Releases the FU with a yumi pulse when the CDB grants.
- Sits between the add-unit reservation stations and the add FU / CDB arbiter in the execute stage.

Parameters:
- NUM_RS, 4, number of requesting RS entries (2..8).
- IDX_W, $clog2(NUM_RS), width of the round-robin pointer.
- CNT_W, 16, width of the issue performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- req_valid  in  NUM_RS  RS entry i has both operands ready and requests issue.
- req_aluop  in  NUM_RS x 4  ALUop per entry.
- req_rob  in  NUM_RS x 4  destination ROB entry per entry.
- req_rs1, req_rs2  in  NUM_RS x 32  operands per entry.
- req_btype  in  NUM_RS x 3  branch_type per entry.
- req_load  in  NUM_RS  load address-step flag per entry.
- grant  out  NUM_RS  one-hot issue grant; RS entry i frees itself on grant[i].
- fu_valid_in  out  1  issue strobe to the FU.
- fu_aluop, fu_rob, fu_rs1, fu_rs2, fu_btype, fu_load  out  4/4/32/32/3/1  muxed operands of the granted entry.
- fu_ready  in  1  FU ready.
- fu_valid_out  in  1  FU result valid.
- cdb_req  out  1  request the CDB for the FU result.
- cdb_gnt  in  1  CDB arbiter grant.
- fu_yumi  out  1  result consumed; clears the FU.
- busy  out  1  state != IDLE.
- issue_cnt  out  CNT_W  count of issues, wraps at 2^CNT_W.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, rr_ptr=0, issue_cnt=0. Outputs are then grant=0, fu_valid_in=0, cdb_req=0, fu_yumi=0, busy=0, fu_* operands=0.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - issue = fu_ready & |req_valid.
  - grant = first set req_valid bit searching rr_ptr, rr_ptr+1, ... mod NUM_RS. This is combinational, in the same cycle.
  - fu_valid_in = issue. fu_* = fields of the granted entry; zeros when there is no grant.
  - On issue: rr_ptr <= (granted index + 1) mod NUM_RS, issue_cnt++, state -> EXEC.
  - No requests or fu_ready==0: hold in IDLE, grant=0.
- EXEC: grant=0, fu_valid_in=0. Wait for fu_valid_out, then -> WB. Nominal dwell is 1 cycle; any longer dwell is allowed.
- WB: cdb_req=1. When cdb_gnt=1: fu_yumi=1 (combinational, same cycle) and -> IDLE. Otherwise hold cdb_req.
- No back-to-back issue: the earliest next grant is the cycle after fu_yumi. Issue-to-issue minimum is 3 cycles.
- grant is at most one-hot, and is never asserted outside IDLE.
- rr_ptr changes only on issue.
- cdb_gnt ignored outside WB. fu_valid_out ignored outside EXEC.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. An in-flight result is dropped; the ROB flush owns recovery.
- issue_cnt wraps from all-ones to 0 without a flag.

Optional Feature:
- Macro: ADD_ISSUE_ARB_FLUSH_EN.
- When defined, adds input flush (1 bit).
  - flush=1 in EXEC or WB: fu_yumi=1 that cycle, state -> IDLE, cdb_req forced 0.
  - flush=1 in IDLE: suppresses grant and fu_valid_in that cycle.
  - rr_ptr and issue_cnt are unaffected by flush.
- When undefined: no flush port; a squash only takes effect via reset.

Test Plan:
- Reset hold: reset=0 for 2 cycles with req_valid=4'b1111 -> grant=0, fu_valid_in=0, issue_cnt=0, busy=0.
- Single issue: req_valid=4'b0100, req_rs1[2]=5, req_rs2[2]=3, req_rob[2]=9, fu_ready=1 -> grant=4'b0100, fu_rs1=5, fu_rob=9, fu_valid_in=1 that cycle; EXEC next; fu_valid_out then WB with cdb_req=1; cdb_gnt at cycle +4 -> fu_yumi=1 same cycle, IDLE next, issue_cnt=1.
- Round-robin: req_valid held at 4'b1111, cdb_gnt always 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
- Wrap-around pointer: after granting entry 3, req_valid=4'b1001 -> next grant=4'b0001. After granting entry 0, req_valid=4'b1001 -> next grant=4'b1000.
- CDB stall: cdb_gnt held 0 for 5 cycles in WB while req_valid=4'b0011 -> cdb_req stays 1, grant=0, fu_yumi=0; cdb_gnt=1 -> fu_yumi pulse, next IDLE cycle grants.
- fu_ready=0 with req_valid=4'b0010 -> no grant, state IDLE. With ADD_ISSUE_ARB_FLUSH_EN: flush=1 in WB -> fu_yumi=1, cdb_req=0, IDLE next.

Source files
------------

// File: rtl/add_issue_arb.sv
// add_issue_arb -- issue scheduler for the add/sub/logic/branch functional unit.
//
// This block shares one FU among NUM_RS reservation-station entries. It picks
// entries in round-robin order. It issues the picked entry to the FU, waits
// for the FU result, requests the CDB, and releases the FU with fu_yumi when
// the CDB grants. Only one operation is in flight at a time, so issues are at
// least three cycles apart.
//
// Configuration macro: ADD_ISSUE_ARB_FLUSH_EN
//   When defined, the block adds a 1-bit flush input. A flush in EXEC or WB
//   drops the in-flight result: fu_yumi pulses, cdb_req is forced low and the
//   state returns to IDLE. A flush in IDLE suppresses that cycle's grant.
//   Flush does not change rr_ptr or issue_cnt.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-low reset
//   req_valid[i]        RS entry i has both operands ready and requests issue
//   req_aluop/rob/rs1/rs2/btype/load   per-entry operation fields
//   grant[i]            one-hot issue grant; entry i frees itself on it
//   fu_valid_in         issue strobe to the FU
//   fu_aluop..fu_load   fields of the granted entry (zero when no grant)
//   fu_ready            FU can accept an operation
//   fu_valid_out        FU result is valid
//   cdb_req / cdb_gnt   CDB write-back request / grant
//   fu_yumi             result consumed; clears the FU
//   busy                an operation is in flight (state != IDLE)
//   issue_cnt           wrapping count of issued operations

module add_issue_arb #(
    parameter int NUM_RS = 4,
    parameter int IDX_W  = $clog2(NUM_RS),
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RS-1:0]        req_valid,
    input  logic [NUM_RS-1:0][3:0]   req_aluop,
    input  logic [NUM_RS-1:0][3:0]   req_rob,
    input  logic [NUM_RS-1:0][31:0]  req_rs1,
    input  logic [NUM_RS-1:0][31:0]  req_rs2,
    input  logic [NUM_RS-1:0][2:0]   req_btype,
    input  logic [NUM_RS-1:0]        req_load,
    output logic [NUM_RS-1:0]        grant,
    output logic                     fu_valid_in,
    output logic [3:0]               fu_aluop,
    output logic [3:0]               fu_rob,
    output logic [31:0]              fu_rs1,
    output logic [31:0]              fu_rs2,
    output logic [2:0]               fu_btype,
    output logic                     fu_load,
    input  logic                     fu_ready,
    input  logic                     fu_valid_out,
    output logic                     cdb_req,
    input  logic                     cdb_gnt,
    output logic                     fu_yumi,
`ifdef ADD_ISSUE_ARB_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     busy,
    output logic [CNT_W-1:0]         issue_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt_q;

    logic               flush_w;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W:0]     nxt_sum;
    logic [IDX_W-1:0]   rr_nxt;
    logic               issue;

`ifdef ADD_ISSUE_ARB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Round-robin search: the first requesting entry at rr_ptr, rr_ptr+1, ...
    // The extra sum bit makes the modulo correct when NUM_RS is not a power
    // of two.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            pick_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (pick_sum >= (IDX_W+1)'(NUM_RS)) begin
                pick_sum = pick_sum - (IDX_W+1)'(NUM_RS);
            end
            if (!pick_found && req_valid[pick_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_sum[IDX_W-1:0];
            end
        end
    end

    // The pointer resumes the search just past the entry that was granted.
    always_comb begin
        nxt_sum = {1'b0, pick_idx} + (IDX_W+1)'(1);
        rr_nxt  = nxt_sum[IDX_W-1:0];
        if (nxt_sum >= (IDX_W+1)'(NUM_RS)) begin
            rr_nxt = '0;
        end
    end

    // Outputs are also gated by reset, so every output reads zero while
    // reset is held.
    assign issue = reset && (state == IDLE) && fu_ready && pick_found && !flush_w;

    always_comb begin
        grant    = '0;
        fu_aluop = '0;
        fu_rob   = '0;
        fu_rs1   = '0;
        fu_rs2   = '0;
        fu_btype = '0;
        fu_load  = 1'b0;
        if (issue) begin
            grant[pick_idx] = 1'b1;
            fu_aluop        = req_aluop[pick_idx];
            fu_rob          = req_rob[pick_idx];
            fu_rs1          = req_rs1[pick_idx];
            fu_rs2          = req_rs2[pick_idx];
            fu_btype        = req_btype[pick_idx];
            fu_load         = req_load[pick_idx];
        end
    end

    assign fu_valid_in = issue;
    assign cdb_req     = reset && (state == WB) && !flush_w;
    assign fu_yumi     = reset && (((state == WB) && (cdb_gnt || flush_w)) ||
                                   ((state == EXEC) && flush_w));
    assign busy        = reset && (state != IDLE);
    assign issue_cnt   = cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        rr_ptr <= rr_nxt;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush_w) begin
                        state <= IDLE;
                    end else if (fu_valid_out) begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (cdb_gnt || flush_w) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_issue_arb.sv
// Self-checking bench for add_issue_arb. Directed scenarios come first, then a
// randomized run. Every cycle of the randomized run is compared against a
// transaction-level model of the FU occupancy. The counter is narrowed to
// 4 bits here so that counter wrap is reachable in a few dozen cycles.

module tb_add_issue_arb;

    localparam int N  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [N-1:0]        req_valid;
    logic [N-1:0][3:0]   req_aluop;
    logic [N-1:0][3:0]   req_rob;
    logic [N-1:0][31:0]  req_rs1;
    logic [N-1:0][31:0]  req_rs2;
    logic [N-1:0][2:0]   req_btype;
    logic [N-1:0]        req_load;
    logic [N-1:0]        grant;
    logic                fu_valid_in;
    logic [3:0]          fu_aluop, fu_rob;
    logic [31:0]         fu_rs1, fu_rs2;
    logic [2:0]          fu_btype;
    logic                fu_load;
    logic                fu_ready, fu_valid_out, cdb_req, cdb_gnt, fu_yumi, busy;
    logic                flush;
    logic [CW-1:0]       issue_cnt;

    add_issue_arb #(.NUM_RS(N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_aluop(req_aluop), .req_rob(req_rob),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_btype(req_btype),
        .req_load(req_load),
        .grant(grant), .fu_valid_in(fu_valid_in),
        .fu_aluop(fu_aluop), .fu_rob(fu_rob), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
        .fu_btype(fu_btype), .fu_load(fu_load),
        .fu_ready(fu_ready), .fu_valid_out(fu_valid_out),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .fu_yumi(fu_yumi),
`ifdef ADD_ISSUE_ARB_FLUSH_EN
        .flush(flush),
`endif
        .busy(busy), .issue_cnt(issue_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model. It tracks whether the FU holds an operation, whether
    // that operation's result has come back, where the next search starts,
    // and how many issues have happened.
    bit m_held;
    bit m_back;
    int m_start;
    int m_cnt;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         vin;
        logic         cdb;
        logic         yumi;
        logic         busy;
        logic [3:0]   aluop;
        logic [3:0]   rob;
        logic [31:0]  rs1;
        logic [31:0]  rs2;
        logic [2:0]   btype;
        logic         load;
    } obs_t;

    function automatic int model_pick();
        logic [1:0] p;
        for (int k = 0; k < N; k++) begin
            p = 2'((m_start + k) % N);
            if (req_valid[p]) return int'(p);
        end
        return -1;
    endfunction

    function automatic obs_t model_expect();
        obs_t       e;
        int         p;
        logic [1:0] pi;
        e = '0;
        if (!reset) return e;
        e.busy = m_held;
        if (!m_held) begin
            p = model_pick();
            if (fu_ready && p >= 0 && !flush) begin
                pi        = 2'(p);
                e.grant   = N'(1) << pi;
                e.vin     = 1'b1;
                e.aluop   = req_aluop[pi];
                e.rob     = req_rob[pi];
                e.rs1     = req_rs1[pi];
                e.rs2     = req_rs2[pi];
                e.btype   = req_btype[pi];
                e.load    = req_load[pi];
            end
        end else if (m_back) begin
            e.cdb  = !flush;
            e.yumi = cdb_gnt || flush;
        end else begin
            e.yumi = flush;
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t a;
        a = '{grant: grant, vin: fu_valid_in, cdb: cdb_req, yumi: fu_yumi,
              busy: busy, aluop: fu_aluop, rob: fu_rob, rs1: fu_rs1,
              rs2: fu_rs2, btype: fu_btype, load: fu_load};
        return a;
    endfunction

    function automatic void model_step();
        int p;
        if (!reset) begin
            m_held = 0; m_back = 0; m_start = 0; m_cnt = 0;
        end else if (!m_held) begin
            p = model_pick();
            if (fu_ready && p >= 0 && !flush) begin
                m_start = (p + 1) % N;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_held  = 1;
                m_back  = 0;
            end
        end else if (!m_back) begin
            if (flush) m_held = 0;
            else if (fu_valid_out) m_back = 1;
        end else if (cdb_gnt || flush) begin
            m_held = 0;
            m_back = 0;
        end
    endfunction

    // Advance one clock. The model consumes the inputs that were stable
    // across the edge, and new stimulus may be driven afterwards.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_aluop = '0; req_rob = '0; req_rs1 = '0;
        req_rs2 = '0; req_btype = '0; req_load = '0;
        fu_ready = 1'b1; fu_valid_out = 1'b0; cdb_gnt = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if ({grant, fu_valid_in, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b vin=%b busy=%b, want all 0", grant, fu_valid_in, busy);
        end
        n_tests++;
        if (issue_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", issue_cnt);
        end
        tick();
    endtask

    task automatic test_single_issue();
        reset        = 1'b1;
        req_valid    = 4'b0100;
        req_rs1[2]   = 32'd5;
        req_rs2[2]   = 32'd3;
        req_rob[2]   = 4'd9;
        fu_ready     = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({grant, fu_valid_in} !== {4'b0100, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b vin=%b want 0100/1", grant, fu_valid_in);
        end
        n_tests++;
        if ({fu_rs1, fu_rs2, fu_rob} !== {32'd5, 32'd3, 4'd9}) begin
            n_fail++;
            $display("FAIL single_fields: rs1=%0d rs2=%0d rob=%0d want 5/3/9", fu_rs1, fu_rs2, fu_rob);
        end
        tick();
        req_valid    = '0;
        fu_valid_out = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, grant, fu_valid_in, cdb_req} !== {1'b1, 4'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_exec: busy=%b grant=%b vin=%b cdb_req=%b want 1/0000/0/0", busy, grant, fu_valid_in, cdb_req);
        end
        tick();
        fu_valid_out = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({cdb_req, fu_yumi} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_wb_wait: cdb_req=%b yumi=%b want 1/0", cdb_req, fu_yumi);
        end
        tick();
        cdb_gnt = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({cdb_req, fu_yumi} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_yumi: cdb_req=%b yumi=%b want 1/1", cdb_req, fu_yumi);
        end
        tick();
        cdb_gnt = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, fu_yumi, issue_cnt} !== {1'b0, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL single_done: busy=%b yumi=%b cnt=%0d want 0/0/1", busy, fu_yumi, issue_cnt);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        req_valid    = 4'b1111;
        fu_valid_out = 1'b1;
        cdb_gnt      = 1'b1;
        fu_ready     = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            exp_g = (c % 3 == 0) ? (N'(1) << ((c / 3) % N)) : '0;
            n_tests++;
            if (grant !== exp_g) begin
                n_fail++;
                $display("FAIL rr_grant_c%0d: got %b want %b", c, grant, exp_g);
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (issue_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL rr_cnt: got %0d want 5", issue_cnt);
        end
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_seq [3];
        exp_seq[0] = 4'b1000;
        exp_seq[1] = 4'b0001;
        exp_seq[2] = 4'b1000;
        req_valid = 4'b1001;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            n_tests++;
            if (grant !== exp_seq[r]) begin
                n_fail++;
                $display("FAIL wrap_grant_%0d: got %b want %b", r, grant, exp_seq[r]);
            end
            tick();
            @(negedge clk);
            n_tests++;
            if (grant !== 4'b0) begin
                n_fail++;
                $display("FAIL wrap_exec_grant_%0d: got %b want 0000", r, grant);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_cdb_stall();
        req_valid    = 4'b0011;
        cdb_gnt      = 1'b0;
        fu_valid_out = 1'b1;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_first_grant: got %b want 0001", grant);
        end
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({cdb_req, grant, fu_yumi} !== {1'b1, 4'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_wb_c%0d: cdb_req=%b grant=%b yumi=%b want 1/0000/0", c, cdb_req, grant, fu_yumi);
            end
            tick();
        end
        cdb_gnt = 1'b1;
        @(negedge clk);
        n_tests++;
        if (fu_yumi !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_yumi: got %b want 1", fu_yumi);
        end
        tick();
        cdb_gnt = 1'b0;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_next_grant: got %b want 0010", grant);
        end
        tick();
        req_valid = '0;
        tick();
        cdb_gnt = 1'b1;
        tick();
        cdb_gnt = 1'b0;
    endtask

    task automatic test_not_ready();
        fu_ready  = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({grant, fu_valid_in, busy} !== 6'b0) begin
                n_fail++;
                $display("FAIL not_ready_c%0d: grant=%b vin=%b busy=%b want all 0", c, grant, fu_valid_in, busy);
            end
            tick();
        end
        fu_ready  = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_cnt_wrap();
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        req_valid    = 4'b1111;
        fu_valid_out = 1'b1;
        cdb_gnt      = 1'b1;
        for (int c = 0; c <= 51; c++) begin
            @(negedge clk);
            if (c == 48 || c == 51) begin
                n_tests++;
                if (issue_cnt !== 4'((c / 3) % 16)) begin
                    n_fail++;
                    $display("FAIL cnt_wrap_c%0d: got %0d want %0d", c, issue_cnt, (c / 3) % 16);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        cdb_gnt      = 1'b0;
        fu_valid_out = 1'b0;
    endtask

`ifdef ADD_ISSUE_ARB_FLUSH_EN
    task automatic test_flush();
        int cnt_before;
        req_valid    = 4'b0001;
        fu_valid_out = 1'b1;
        cdb_gnt      = 1'b0;
        tick();
        req_valid = '0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({fu_yumi, cdb_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_wb: yumi=%b cdb_req=%b want 1/0", fu_yumi, cdb_req);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wb_idle: busy=%b want 0", busy);
        end
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        flush     = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({fu_yumi, cdb_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_exec: yumi=%b cdb_req=%b want 1/0", fu_yumi, cdb_req);
        end
        tick();
        req_valid  = 4'b1111;
        cnt_before = m_cnt;
        @(negedge clk);
        n_tests++;
        if ({grant, fu_valid_in, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL flush_idle: grant=%b vin=%b busy=%b want all 0", grant, fu_valid_in, busy);
        end
        tick();
        flush     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (issue_cnt !== 4'(cnt_before)) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d want %0d", issue_cnt, cnt_before);
        end
        tick();
        fu_valid_out = 1'b0;
    endtask
`endif

    task automatic test_random();
        obs_t e;
        obs_t a;
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 59) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_aluop[i] = 4'($urandom);
                req_rob[i]   = 4'($urandom);
                req_rs1[i]   = $urandom;
                req_rs2[i]   = $urandom;
                req_btype[i] = 3'($urandom);
                req_load[i]  = 1'($urandom);
            end
            fu_ready     = ($urandom_range(0, 3) != 0);
            fu_valid_out = 1'($urandom);
            cdb_gnt      = 1'($urandom);
`ifdef ADD_ISSUE_ARB_FLUSH_EN
            flush        = ($urandom_range(0, 9) == 0);
`endif
            @(negedge clk);
            e = model_expect();
            a = observed();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL rand_outputs_c%0d: got %h want %h", c, a, e);
            end
            n_tests++;
            if (issue_cnt !== 4'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_cnt_c%0d: got %0d want %0d", c, issue_cnt, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        m_held = 0; m_back = 0; m_start = 0; m_cnt = 0;
        reset  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_issue();
        test_round_robin();
        test_wrap();
        test_cdb_stall();
        test_not_ready();
        test_cnt_wrap();
`ifdef ADD_ISSUE_ARB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
